lfdb_wr_channel_sched: RTL and testbench

LFDB_WR_CHANNEL_SCHED -- requirements
Module: lfdb_wr_channel_sched

---
 rtl/lfdb_wr_channel_sched.sv | 129 ++++++++++++
 tb/tb_lfdb_wr_channel_sched.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfdb_wr_channel_sched.sv
// Write-channel scheduler: round-robin grant against a shifting reservation calendar; req_rdy is same-cycle, grant registered +1.
// Requesters wait (req_rdy=0) until their delayed occupancy window is free; sched_en=0 stops new grants while reservations drain.
module lfdb_wr_channel_sched #(
  parameter int SRC_NUM    = 5,
  parameter int PLD_WIDTH  = 64,
  parameter int OCC_CYCLES = 4,
  parameter int D_WEST     = 2,
  parameter int D_EAST     = 3,
  parameter int D_SOUTH    = 6,
  parameter int D_NORTH    = 4,
  parameter int D_LF       = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sched_en,
  input  logic [SRC_NUM-1:0]            req_vld,
  input  logic [SRC_NUM*PLD_WIDTH-1:0]  req_pld,
  output logic [SRC_NUM-1:0]            req_rdy,
  output logic                          gnt_vld,
  output logic [2:0]                    gnt_src,
  output logic [PLD_WIDTH-1:0]          gnt_pld,
  output logic                          ch_busy,
  output logic [2:0]                    ch_src
);

  function automatic int dly(input int k);
    case (k)
      0:       return D_WEST;
      1:       return D_EAST;
      2:       return D_SOUTH;
      3:       return D_NORTH;
      default: return D_LF;
    endcase
  endfunction

  function automatic int max_dly();
    int m;
    m = 0;
    for (int k = 0; k < 5; k++)
      if (dly(k) > m) m = dly(k);
    return m;
  endfunction

  localparam int WIN = max_dly() + OCC_CYCLES;

  if (SRC_NUM < 1 || SRC_NUM > 5) begin : g_bad_src_num
    $error("SRC_NUM must be in 1..5");
  end
  for (genvar g = 0; g < SRC_NUM; g++) begin : g_chk_dly
    if (dly(g) < 1 || dly(g) + OCC_CYCLES > WIN) begin : g_bad_dly
      $error("source delay out of range");
    end
  end

  logic [WIN-1:0]       res, res_nxt;
  logic [WIN-1:0][2:0]  tag, tag_nxt;
  logic [2:0]           rr_ptr;
  logic [SRC_NUM-1:0]   elig;
  logic                 found;
  logic [2:0]           win;

  // Eligibility looks at the pre-shift calendar: slot D_k+j is the same absolute cycle the grant would occupy.
  always_comb begin
    for (int k = 0; k < SRC_NUM; k++) begin
      elig[k] = rst_n & sched_en & req_vld[k];
      for (int j = 0; j < OCC_CYCLES; j++)
        if (res[dly(k) + j]) elig[k] = 1'b0;
    end
  end

  always_comb begin
    int idx;
    found   = 1'b0;
    win     = 3'd0;
    req_rdy = '0;
    for (int off = 0; off < SRC_NUM; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= SRC_NUM) idx = idx - SRC_NUM;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
    for (int k = 0; k < SRC_NUM; k++)
      req_rdy[k] = found && (int'(win) == k);
  end

  // Next calendar is one cycle later, so the winner's window lands one slot lower than where it was checked.
  always_comb begin
    int lo;
    int hi;
    lo      = dly(int'(win)) - 1;
    hi      = lo + OCC_CYCLES - 1;
    res_nxt = {1'b0, res[WIN-1:1]};
    tag_nxt = {3'b000, tag[WIN-1:1]};
    if (found) begin
      for (int i = 0; i < WIN; i++) begin
        if (i >= lo && i <= hi) begin
          res_nxt[i] = 1'b1;
          tag_nxt[i] = win;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res     <= '0;
      tag     <= '0;
      rr_ptr  <= 3'd0;
      gnt_vld <= 1'b0;
      gnt_src <= 3'd0;
      gnt_pld <= '0;
    end else begin
      res     <= res_nxt;
      tag     <= tag_nxt;
      gnt_vld <= found;
      if (found) begin
        gnt_src <= win;
        gnt_pld <= req_pld[int'(win)*PLD_WIDTH +: PLD_WIDTH];
        rr_ptr  <= (int'(win) == SRC_NUM - 1) ? 3'd0 : win + 3'd1;
      end
    end
  end

  assign ch_busy = res[0];
  assign ch_src  = res[0] ? tag[0] : 3'd0;

endmodule

// File: tb/tb_lfdb_wr_channel_sched.sv
// Scoreboard bench for lfdb_wr_channel_sched: directed scenarios plus randomized traffic against an absolute-time channel calendar.
module tb_lfdb_wr_channel_sched;
  localparam int N     = 5;
  localparam int PW    = 64;
  localparam int OCC   = 4;
  localparam int LIMIT = 5 * (OCC + 8);
  localparam int DL [N] = '{2, 3, 6, 4, 8};

  logic            clk;
  logic            rst_n;
  logic            sched_en;
  logic [N-1:0]    req_vld;
  logic [N*PW-1:0] req_pld;
  logic [N-1:0]    req_rdy;
  logic            gnt_vld;
  logic [2:0]      gnt_src;
  logic [PW-1:0]   gnt_pld;
  logic            ch_busy;
  logic [2:0]      ch_src;

  lfdb_wr_channel_sched #(
    .SRC_NUM(N), .PLD_WIDTH(PW), .OCC_CYCLES(OCC),
    .D_WEST(2), .D_EAST(3), .D_SOUTH(6), .D_NORTH(4), .D_LF(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
    .req_vld(req_vld), .req_pld(req_pld), .req_rdy(req_rdy),
    .gnt_vld(gnt_vld), .gnt_src(gnt_src), .gnt_pld(gnt_pld),
    .ch_busy(ch_busy), .ch_src(ch_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int            due;
    int            src;
    logic [PW-1:0] pld;
  } gexp_t;

  gexp_t exp_q[$];
  int    cal[int];
  int    m_rr = 0;
  int    m_win;
  int    m_idx;
  int    wait_cnt [N];
  logic [N-1:0] m_elig;
  logic [N-1:0] m_rdy;
  logic  m_busy;
  int    m_src;
  gexp_t m_e;

  // Reference model: bench-owned calendar of absolute busy cycles, its own round-robin pointer, and a grant queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      cal.delete();
      exp_q.delete();
      m_rr = 0;
      for (int k = 0; k < N; k++) wait_cnt[k] = 0;
      n_chk++;
      if ({gnt_vld, ch_busy, ch_src, req_rdy} !== '0) begin
        n_fail++;
        $display("FAIL mon_reset_outputs: gnt_vld=%b ch_busy=%b ch_src=%0d req_rdy=%b, required all 0", gnt_vld, ch_busy, ch_src, req_rdy);
      end
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        m_e = exp_q.pop_front();
        n_chk++;
        if (gnt_vld !== 1'b1 || gnt_src !== 3'(m_e.src) || gnt_pld !== m_e.pld) begin
          n_fail++;
          $display("FAIL mon_grant @%0d: vld=%b src=%0d pld=%h, required vld=1 src=%0d pld=%h", cyc, gnt_vld, gnt_src, gnt_pld, m_e.src, m_e.pld);
        end
      end else begin
        n_chk++;
        if (gnt_vld !== 1'b0) begin
          n_fail++;
          $display("FAIL mon_spurious_grant @%0d: gnt_vld=%b, required 0", cyc, gnt_vld);
        end
      end
      m_busy = cal.exists(cyc);
      m_src  = m_busy ? cal[cyc] : 0;
      if (m_busy) cal.delete(cyc);
      n_chk++;
      if (ch_busy !== m_busy || ch_src !== 3'(m_src)) begin
        n_fail++;
        $display("FAIL mon_channel @%0d: busy=%b src=%0d, required busy=%b src=%0d", cyc, ch_busy, ch_src, m_busy, m_src);
      end
      for (int k = 0; k < N; k++) begin
        m_elig[k] = sched_en & req_vld[k];
        for (int j = 0; j < OCC; j++)
          if (cal.exists(cyc + DL[k] + j)) m_elig[k] = 1'b0;
      end
      m_win = -1;
      for (int off = 0; off < N; off++) begin
        m_idx = (m_rr + off) % N;
        if (m_win < 0 && m_elig[m_idx]) m_win = m_idx;
      end
      m_rdy = '0;
      if (m_win >= 0) m_rdy[m_win] = 1'b1;
      n_chk++;
      if (req_rdy !== m_rdy) begin
        n_fail++;
        $display("FAIL mon_req_rdy @%0d: req_rdy=%b, required %b (vld=%b en=%b)", cyc, req_rdy, m_rdy, req_vld, sched_en);
      end
      for (int k = 0; k < N; k++) begin
        if (k == m_win) begin
          n_chk++;
          if (wait_cnt[k] > LIMIT) begin
            n_fail++;
            $display("FAIL mon_starvation src %0d: waited %0d cycles, limit %0d", k, wait_cnt[k], LIMIT);
          end
          wait_cnt[k] = 0;
        end else if (m_elig[k]) begin
          wait_cnt[k]++;
        end else begin
          wait_cnt[k] = 0;
        end
      end
      if (m_win >= 0) begin
        for (int j = 0; j < OCC; j++) cal[cyc + DL[m_win] + j] = m_win;
        m_e.due = cyc + 1;
        m_e.src = m_win;
        m_e.pld = req_pld[m_win*PW +: PW];
        exp_q.push_back(m_e);
        m_rr = (m_win + 1) % N;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  function automatic logic [PW-1:0] pld_of(input int k);
    return 64'hC0DE_0000_0000_0000 | 64'(k);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pld();
    for (int k = 0; k < N; k++) req_pld[k*PW +: PW] = pld_of(k);
  endtask

  task automatic drain();
    req_vld = '0;
    repeat (14) step();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if ({gnt_vld, gnt_src, gnt_pld, ch_busy, ch_src, req_rdy} !== '0) begin
        n_fail++;
        $display("FAIL reset_state: gnt_vld=%b gnt_src=%0d gnt_pld=%h ch_busy=%b ch_src=%0d req_rdy=%b, required all 0",
                 gnt_vld, gnt_src, gnt_pld, ch_busy, ch_src, req_rdy);
      end
    end
    step();
    rst_n = 1'b1;
  endtask

  // West and east held together from an idle channel with rr_ptr=0: back-to-back windows, no gap.
  task automatic test_back_to_back();
    logic [N-1:0] rdy_tab [4] = '{5'b00001, 5'b00000, 5'b00000, 5'b00010};
    logic exp_g, exp_b;
    int   exp_s;
    set_pld();
    step();
    req_vld = 5'b00011;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) req_vld = '0;
      @(negedge clk);
      if (i < 4) begin
        n_chk++;
        if (req_rdy !== rdy_tab[i]) begin
          n_fail++;
          $display("FAIL b2b_rdy t0+%0d: req_rdy=%b, required %b", i, req_rdy, rdy_tab[i]);
        end
      end
      exp_g = (i == 1) || (i == 4);
      exp_s = (i == 4) ? 1 : 0;
      n_chk++;
      if (gnt_vld !== exp_g || (exp_g && (gnt_src !== 3'(exp_s) || gnt_pld !== pld_of(exp_s)))) begin
        n_fail++;
        $display("FAIL b2b_grant t0+%0d: vld=%b src=%0d, required vld=%b src=%0d", i, gnt_vld, gnt_src, exp_g, exp_s);
      end
      exp_b = (i >= 2) && (i <= 9);
      exp_s = (i >= 6 && exp_b) ? 1 : 0;
      n_chk++;
      if (ch_busy !== exp_b || ch_src !== 3'(exp_s)) begin
        n_fail++;
        $display("FAIL b2b_channel t0+%0d: busy=%b src=%0d, required busy=%b src=%0d", i, ch_busy, ch_src, exp_b, exp_s);
      end
      step();
    end
  endtask

  task automatic apply_reset();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // West then south: south's longer delay lets it be granted the next cycle, leaving exactly one idle cycle.
  task automatic test_west_south();
    logic exp_b;
    int   exp_s;
    set_pld();
    step();
    req_vld = 5'b00101;
    @(negedge clk);
    n_chk++;
    if (req_rdy !== 5'b00001) begin
      n_fail++;
      $display("FAIL ws_rdy_west: req_rdy=%b, required 00001", req_rdy);
    end
    step();
    req_vld = 5'b00100;
    @(negedge clk);
    n_chk++;
    if (req_rdy !== 5'b00100) begin
      n_fail++;
      $display("FAIL ws_rdy_south: req_rdy=%b, required 00100", req_rdy);
    end
    step();
    req_vld = '0;
    for (int i = 2; i < 13; i++) begin
      @(negedge clk);
      if (i == 2) begin
        n_chk++;
        if (gnt_vld !== 1'b1 || gnt_src !== 3'd2 || gnt_pld !== pld_of(2)) begin
          n_fail++;
          $display("FAIL ws_grant_south: vld=%b src=%0d pld=%h, required vld=1 src=2 pld=%h", gnt_vld, gnt_src, gnt_pld, pld_of(2));
        end
      end
      exp_b = (i >= 2 && i <= 5) || (i >= 7 && i <= 10);
      exp_s = (i >= 7 && i <= 10) ? 2 : 0;
      n_chk++;
      if (ch_busy !== exp_b || ch_src !== 3'(exp_s)) begin
        n_fail++;
        $display("FAIL ws_channel t0+%0d: busy=%b src=%0d, required busy=%b src=%0d", i, ch_busy, ch_src, exp_b, exp_s);
      end
      step();
    end
  endtask

  task automatic test_single();
    logic exp_b;
    drain();
    set_pld();
    req_vld = 5'b00001;
    @(negedge clk);
    n_chk++;
    if (req_rdy !== 5'b00001) begin
      n_fail++;
      $display("FAIL single_rdy: req_rdy=%b, required 00001", req_rdy);
    end
    step();
    req_vld = '0;
    for (int i = 1; i < 9; i++) begin
      @(negedge clk);
      n_chk++;
      if (gnt_vld !== (i == 1) || (i == 1 && (gnt_src !== 3'd0 || gnt_pld !== pld_of(0)))) begin
        n_fail++;
        $display("FAIL single_grant t0+%0d: vld=%b src=%0d, required vld=%b src=0", i, gnt_vld, gnt_src, (i == 1));
      end
      exp_b = (i >= 2) && (i <= 5);
      n_chk++;
      if (ch_busy !== exp_b || ch_src !== 3'd0) begin
        n_fail++;
        $display("FAIL single_channel t0+%0d: busy=%b src=%0d, required busy=%b src=0", i, ch_busy, ch_src, exp_b);
      end
      step();
    end
  endtask

  task automatic test_sched_disable();
    logic exp_b;
    drain();
    set_pld();
    req_vld = 5'b00001;
    @(negedge clk);
    n_chk++;
    if (req_rdy !== 5'b00001) begin
      n_fail++;
      $display("FAIL dis_first_rdy: req_rdy=%b, required 00001", req_rdy);
    end
    step();
    sched_en = 1'b0;
    req_vld  = 5'b11111;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      exp_b = (i >= 2) && (i <= 5);
      n_chk++;
      if (req_rdy !== 5'b00000 || ch_busy !== exp_b) begin
        n_fail++;
        $display("FAIL dis_hold t0+%0d: req_rdy=%b busy=%b, required rdy=00000 busy=%b", i, req_rdy, ch_busy, exp_b);
      end
      step();
    end
    req_vld  = '0;
    sched_en = 1'b1;
  endtask

  // Linefill reservation is discarded by a mid-window reset; a west request at release must behave as from idle.
  task automatic test_reset_mid();
    logic exp_b;
    drain();
    set_pld();
    req_vld = 5'b10000;
    @(negedge clk);
    n_chk++;
    if (req_rdy !== 5'b10000) begin
      n_fail++;
      $display("FAIL rmid_rdy_lf: req_rdy=%b, required 10000", req_rdy);
    end
    step();
    req_vld = '0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({gnt_vld, gnt_src, gnt_pld, ch_busy, ch_src} !== '0) begin
      n_fail++;
      $display("FAIL rmid_async_clear: gnt_vld=%b gnt_src=%0d gnt_pld=%h busy=%b src=%0d, required all 0",
               gnt_vld, gnt_src, gnt_pld, ch_busy, ch_src);
    end
    repeat (4) step();
    rst_n   = 1'b1;
    req_vld = 5'b00001;
    @(negedge clk);
    n_chk++;
    if (req_rdy !== 5'b00001) begin
      n_fail++;
      $display("FAIL rmid_first_after_release: req_rdy=%b, required 00001", req_rdy);
    end
    step();
    req_vld = '0;
    for (int j = 1; j < 13; j++) begin
      @(negedge clk);
      exp_b = (j >= 2) && (j <= 5);
      n_chk++;
      if (ch_busy !== exp_b || ch_src !== 3'd0) begin
        n_fail++;
        $display("FAIL rmid_channel r+%0d: busy=%b src=%0d, required busy=%b src=0", j, ch_busy, ch_src, exp_b);
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    logic [N-1:0] acc;
    pend = '0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      acc = req_vld & req_rdy;
      step();
      pend = pend & ~acc;
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 3) == 0) pend[k] = 1'b1;
        req_pld[k*PW +: PW] = {$urandom, $urandom};
      end
      req_vld  = pend;
      sched_en = ($urandom_range(0, 15) != 0);
    end
    req_vld  = '0;
    sched_en = 1'b1;
    repeat (20) step();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_grants_outstanding: %0d expected grants never seen, required 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    sched_en = 1'b1;
    req_vld  = '0;
    req_pld  = '0;
    test_reset();
    test_back_to_back();
    apply_reset();
    test_west_south();
    test_single();
    test_sched_disable();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
